// File: rtl/sap_pkg.sv
// Shared types and sizing for the SAP program loader: FSM state encoding,
// memory geometry and the length-validity helper.
package sap_pkg;

    localparam int MEM_DEPTH  = 16;
    localparam int MEM_ADDR_W = 4;
    localparam int DATA_W     = 8;
    localparam int IDX_W      = MEM_ADDR_W + 1;
    localparam int BIT_CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECV_LEN   = 3'd1,
        RECV_DATA  = 3'd2,
        SET_ADR    = 3'd3,
        WRITE_DATA = 3'd4,
        FINISH     = 3'd5
    } loader_state_t;

    // A length byte is usable only if it fits the RAM without wrapping.
    function automatic logic len_ok(input logic [DATA_W-1:0] len_byte);
        return (len_byte != '0) && (len_byte <= DATA_W'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/ser_byte_rx.sv
// Serial-to-parallel byte assembler: MSB-first shift on each strobe, one-cycle
// byte-valid pulse on the eighth bit. Disabling it flushes any partial byte.
module ser_byte_rx
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_strobe,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_byte,
    output logic              o_byte_valid
);

    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_byte;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic                 r_valid;
    logic [DATA_W-1:0]    w_shift_next;
    logic                 w_last_bit;

    assign w_shift_next = {r_shift[DATA_W-2:0], i_bit};
    assign w_last_bit   = (r_cnt == {BIT_CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset || !i_enable) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_strobe) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + BIT_CNT_W'(1);
                if (w_last_bit) begin
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // The completed byte is held stable until the next one finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte <= '0;
        end else if (i_enable && i_strobe && w_last_bit) begin
            r_byte <= w_shift_next;
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length byte then that many data bytes over a
// serial link and writes them into CPU RAM at addresses 0..L-1 via the CPU bus.
module prog_loader
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ser_strobe,
    input  logic              ser_bit,
    output logic [DATA_W-1:0] bus_value,
    output logic              bus_drive,
    output logic              en_write_mem_adr,
    output logic              en_write_mem,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_len;
    logic [DATA_W-1:0] r_data;
    logic              r_pend_valid;
    logic [DATA_W-1:0] r_pend_byte;
    logic              r_error;

    logic [DATA_W-1:0] w_rx_byte;
    logic              w_rx_valid;
    logic              w_data_avail;
    logic [DATA_W-1:0] w_data_byte;
    logic [IDX_W-1:0]  w_idx_inc;
    logic              w_len_ok;
    logic              w_write_phase;

    ser_byte_rx u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (cpu_hold),
        .i_strobe     (ser_strobe),
        .i_bit        (ser_bit),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid)
    );

    // A byte that finished during the two bus cycles is taken ahead of the live one.
    assign w_data_avail  = r_pend_valid | w_rx_valid;
    assign w_data_byte   = r_pend_valid ? r_pend_byte : w_rx_byte;
    assign w_idx_inc     = r_idx + IDX_W'(1);
    assign w_len_ok      = len_ok(w_rx_byte);
    assign w_write_phase = (r_state == SET_ADR) || (r_state == WRITE_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RECV_LEN;
                end
            end
            RECV_LEN: begin
                if (w_rx_valid) begin
                    w_state_next = w_len_ok ? RECV_DATA : IDLE;
                end
            end
            RECV_DATA: begin
                if (w_data_avail) begin
                    w_state_next = SET_ADR;
                end
            end
            SET_ADR: begin
                w_state_next = WRITE_DATA;
            end
            WRITE_DATA: begin
                w_state_next = (w_idx_inc == r_len) ? FINISH : RECV_DATA;
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_error <= 1'b0;
                    end
                end
                RECV_LEN: begin
                    if (w_rx_valid) begin
                        if (w_len_ok) begin
                            r_len <= w_rx_byte[IDX_W-1:0];
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                RECV_DATA: begin
                    if (w_data_avail) begin
                        r_data <= w_data_byte;
                    end
                end
                WRITE_DATA: begin
                    r_idx <= w_idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Single-entry holding slot so shifting never has to pause for the bus cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_byte  <= '0;
        end else if (r_state == RECV_DATA) begin
            if (r_pend_valid) begin
                r_pend_valid <= w_rx_valid;
                r_pend_byte  <= w_rx_byte;
            end
        end else if (w_write_phase) begin
            if (w_rx_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_byte  <= w_rx_byte;
            end
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    always_comb begin
        bus_value        = '0;
        bus_drive        = 1'b0;
        en_write_mem_adr = 1'b0;
        en_write_mem     = 1'b0;
        cpu_hold         = 1'b0;
        done             = 1'b0;
        case (r_state)
            RECV_LEN, RECV_DATA: begin
                cpu_hold = 1'b1;
            end
            SET_ADR: begin
                cpu_hold         = 1'b1;
                bus_drive        = 1'b1;
                en_write_mem_adr = 1'b1;
                bus_value        = {{(DATA_W-MEM_ADDR_W){1'b0}}, r_idx[MEM_ADDR_W-1:0]};
            end
            WRITE_DATA: begin
                cpu_hold     = 1'b1;
                bus_drive    = 1'b1;
                en_write_mem = 1'b1;
                bus_value    = r_data;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign error = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a transaction-schedule model predicts every
// output on every cycle, plus literal checks for the directed load scenarios.
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ser_strobe;
    logic       ser_bit;
    logic [7:0] bus_value;
    logic       bus_drive;
    logic       en_write_mem_adr;
    logic       en_write_mem;
    logic       cpu_hold;
    logic       done;
    logic       error;

    prog_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .ser_strobe       (ser_strobe),
        .ser_bit          (ser_bit),
        .bus_value        (bus_value),
        .bus_drive        (bus_drive),
        .en_write_mem_adr (en_write_mem_adr),
        .en_write_mem     (en_write_mem),
        .cpu_hold         (cpu_hold),
        .done             (done),
        .error            (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a session is a hold window [m_hs, m_he] plus scheduled bus events per cycle.
    bit         m_valid = 1'b0;
    int         m_hs = 1;
    int         m_he = 0;
    bit         m_err = 1'b0;
    int         m_bits = 0;
    logic [7:0] m_acc = 8'h00;
    bit         m_have_len = 1'b0;
    int         m_len = 0;
    int         m_sched = 0;
    int         m_ready = 0;
    logic [7:0] e_adr [int];
    logic [7:0] e_wr  [int];
    bit         e_done[int];
    bit         e_err [int];

    logic [7:0] adr_log[$];
    logic [7:0] wr_log[$];
    int         adr_cyc[$];
    int         wr_cyc[$];
    int         done_cnt = 0;
    int         done_last_cyc = -1;
    int         last_bit_edge = 0;

    function automatic bit m_hold(int c);
        return (c >= m_hs) && (c <= m_he);
    endfunction

    // A byte completed at edge n: it is usable from cycle n; each write takes
    // an address cycle and a data cycle once the loader is free again.
    task automatic model_byte(int n, logic [7:0] b);
        int c;
        if (!m_have_len) begin
            if (b >= 8'd1 && b <= 8'd16) begin
                m_have_len = 1'b1;
                m_len      = int'(b);
                m_ready    = n + 1;
            end else begin
                m_he         = n;
                e_err[n + 1] = 1'b1;
            end
        end else if (m_sched < m_len) begin
            c = (n > m_ready) ? n : m_ready;
            e_adr[c + 1] = 8'(m_sched);
            e_wr[c + 2]  = b;
            m_ready      = c + 3;
            m_sched++;
            if (m_sched == m_len) begin
                m_he          = c + 2;
                e_done[c + 3] = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset === 1'b1) begin
                m_valid = 1'b1;
                m_hs    = 1;
                m_he    = 0;
                m_err   = 1'b0;
                e_adr.delete();
                e_wr.delete();
                e_done.delete();
                e_err.delete();
            end else if (m_valid) begin
                if (!m_hold(cyc - 1) && !e_done.exists(cyc - 1) && start === 1'b1) begin
                    m_hs       = cyc;
                    m_he       = 32'h7fff_ffff;
                    m_err      = 1'b0;
                    m_bits     = 0;
                    m_acc      = 8'h00;
                    m_have_len = 1'b0;
                    m_sched    = 0;
                end else if (m_hold(cyc - 1) && ser_strobe === 1'b1) begin
                    m_acc = {m_acc[6:0], ser_bit};
                    m_bits++;
                    if (m_bits == 8) begin
                        m_bits = 0;
                        model_byte(cyc, m_acc);
                    end
                end
                if (e_err.exists(cyc)) m_err = 1'b1;
            end
        end
    end

    logic [7:0]  c_eb;
    bit          c_ea, c_ew, c_ed, c_eh;
    logic [13:0] c_ev, c_av;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                c_ea = e_adr.exists(cyc) != 0;
                c_ew = e_wr.exists(cyc) != 0;
                c_ed = e_done.exists(cyc) != 0;
                c_eh = m_hold(cyc);
                c_eb = c_ea ? e_adr[cyc] : (c_ew ? e_wr[cyc] : 8'h00);
                c_ev = {c_eb, c_ea | c_ew, c_ea, c_ew, c_eh, c_ed, m_err};
                c_av = {bus_value, bus_drive, en_write_mem_adr, en_write_mem, cpu_hold, done, error};
                checks++;
                if (c_av !== c_ev) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got bus=%02h drv=%b adr=%b mem=%b hold=%b done=%b err=%b, want bus=%02h drv=%b adr=%b mem=%b hold=%b done=%b err=%b",
                             cyc, bus_value, bus_drive, en_write_mem_adr, en_write_mem, cpu_hold, done, error,
                             c_eb, c_ea | c_ew, c_ea, c_ew, c_eh, c_ed, m_err);
                end
            end
            if (en_write_mem_adr === 1'b1) begin
                adr_log.push_back(bus_value);
                adr_cyc.push_back(cyc);
            end
            if (en_write_mem === 1'b1) begin
                wr_log.push_back(bus_value);
                wr_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_last_cyc = cyc;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_q(string name, logic [7:0] q[$], logic [7:0] e[$]);
        chk({name, "_count"}, q.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= q.size() || q[i] !== e[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %02h want %02h", name, i,
                         (i < q.size()) ? q[i] : 8'hxx, e[i]);
            end
        end
    endtask

    task automatic clear_logs();
        adr_log.delete();
        wr_log.delete();
        adr_cyc.delete();
        wr_cyc.delete();
        done_cnt      = 0;
        done_last_cyc = -1;
    endtask

    task automatic drive(bit s, bit st, bit b);
        @(negedge clk);
        start      = s;
        ser_strobe = st;
        ser_bit    = b;
    endtask

    task automatic pulse_reset(int n);
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b0;
        ser_strobe = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Noise start pulses only ride on non-final bits, where a session is surely active.
    task automatic send_byte(logic [7:0] b, int maxgap, bit noisy);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) begin
            drive(noisy && (i > 0) && ($urandom_range(0, 4) == 0), 1'b1, v[i]);
            if (i == 0) last_bit_edge = cyc + 1;
            repeat ($urandom_range(0, maxgap)) begin
                drive(noisy && (i > 0) && ($urandom_range(0, 4) == 0), 1'b0, 1'($urandom));
            end
        end
    endtask

    task automatic wait_idle(string name);
        int k;
        k = 0;
        do begin
            drive(1'b0, 1'b0, 1'b0);
            k++;
        end while ((cpu_hold !== 1'b0 || done !== 1'b0) && k < 300);
        chk({name, "_end_in_time"}, k < 300, 1);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] exp_adr[$];
    logic [7:0] exp_wr[$];
    logic [7:0] bytes_q[$];
    logic [7:0] len_b;
    int         t1, k, len, abort_at;
    bit         valid_len, abort;
    logic [7:0] bad_lens[2];

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ser_strobe = 1'b0;
        ser_bit    = 1'b0;
        pulse_reset(2);
        drive(1'b0, 1'b0, 1'b0);
        chk("reset_hold", cpu_hold, 0);
        chk("reset_error", error, 0);
        chk("reset_bus_drive", bus_drive, 0);

        // Basic three-byte load
        clear_logs();
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h1E, 1, 1'b0);
        t1 = last_bit_edge;
        send_byte(8'h2F, 1, 1'b0);
        send_byte(8'hE0, 2, 1'b0);
        wait_idle("basic");
        exp_adr = '{8'h00, 8'h01, 8'h02};
        exp_wr  = '{8'h1E, 8'h2F, 8'hE0};
        chk_q("basic_adr", adr_log, exp_adr);
        chk_q("basic_data", wr_log, exp_wr);
        chk("basic_done_count", done_cnt, 1);
        chk("basic_adr_latency", (adr_cyc.size() > 0) ? adr_cyc[0] : -1, t1 + 1);
        chk("basic_wr_latency", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t1 + 2);
        chk("basic_done_after_write", done_last_cyc, (wr_cyc.size() > 0) ? wr_cyc[$] + 1 : -2);
        chk("basic_hold_after", cpu_hold, 0);

        // Same load with idle strobes beforehand and a second start mid-session
        clear_logs();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'($urandom));
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h03, 1, 1'b1);
        send_byte(8'h1E, 2, 1'b1);
        send_byte(8'h2F, 0, 1'b1);
        send_byte(8'hE0, 1, 1'b0);
        wait_idle("noisy");
        chk_q("noisy_adr", adr_log, exp_adr);
        chk_q("noisy_data", wr_log, exp_wr);
        chk("noisy_done_count", done_cnt, 1);

        // Out-of-range lengths
        bad_lens[0] = 8'h00;
        bad_lens[1] = 8'h11;
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            drive(1'b1, 1'b0, 1'b0);
            send_byte(bad_lens[j], 1, 1'b0);
            wait_idle("badlen");
            chk("badlen_error", error, 1);
            chk("badlen_hold", cpu_hold, 0);
            chk("badlen_adr_strobes", adr_log.size(), 0);
            chk("badlen_wr_strobes", wr_log.size(), 0);
            chk("badlen_done", done_cnt, 0);
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            chk("badlen_error_cleared", error, 0);
            send_byte(8'h01, 0, 1'b0);
            send_byte(8'hA5, 0, 1'b0);
            wait_idle("badlen_recover");
            chk("badlen_recover_done", done_cnt, 1);
        end

        // Full 16-byte load with a strobe every cycle
        clear_logs();
        bytes_q.delete();
        exp_adr.delete();
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h10, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bytes_q.push_back(8'($urandom));
            exp_adr.push_back(8'(i));
            send_byte(bytes_q[i], 0, 1'b0);
        end
        wait_idle("full");
        chk_q("full_adr", adr_log, exp_adr);
        chk_q("full_data", wr_log, bytes_q);
        chk("full_done_count", done_cnt, 1);

        // Reset after the second data write
        clear_logs();
        drive(1'b1, 1'b0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h11, 1, 1'b0);
        send_byte(8'h22, 1, 1'b0);
        k = 0;
        while (wr_log.size() < 2 && k < 100) begin
            drive(1'b0, 1'b1, 1'($urandom));
            k++;
        end
        chk("abort_second_write_seen", k < 100, 1);
        pulse_reset(1);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_hold", cpu_hold, 0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'($urandom));
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        chk("abort_adr_strobes", adr_log.size(), 2);
        chk("abort_wr_strobes", wr_log.size(), 2);
        chk("abort_done", done_cnt, 0);

        // Random sessions
        for (int s = 0; s < 30; s++) begin
            clear_logs();
            bytes_q.delete();
            repeat ($urandom_range(0, 5)) drive(1'b0, 1'b1, 1'($urandom));
            drive(1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 9) == 0) begin
                len_b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
            end else begin
                len_b = 8'($urandom_range(1, 16));
            end
            valid_len = (len_b >= 8'd1) && (len_b <= 8'd16);
            len       = int'(len_b);
            abort     = ($urandom_range(0, 7) == 0);
            abort_at  = $urandom_range(0, 15);
            send_byte(len_b, 3, 1'b1);
            if (valid_len) begin
                for (int i = 0; i < len; i++) begin
                    if (abort && i == abort_at) begin
                        pulse_reset($urandom_range(1, 2));
                        break;
                    end
                    bytes_q.push_back(8'($urandom));
                    send_byte(bytes_q[i], 3, 1'b1);
                end
            end
            wait_idle("rand");
            if (valid_len && !(abort && abort_at < len)) begin
                chk_q("rand_data", wr_log, bytes_q);
                chk("rand_done_count", done_cnt, 1);
            end
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
